// File: rtl/shift_pkg.sv
// Shared encodings for the shift register controller: shift modes and FSM states.
// Mode values match the external Modo port encoding directly.
package shift_pkg;
   typedef enum logic [1:0] {
      SRA = 2'b00,
      SRL = 2'b01,
      SLL = 2'b10,
      ROR = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/shift_step.sv
// One-position combinational shifter; out_bit is the bit that falls off the end.
// Used by both the single-step and the multi-step paths of shift_reg_ctl.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  mode_e            mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] next_value,
   output logic             out_bit
);
   always_comb begin
      next_value = value;
      out_bit    = value[0];
      case (mode)
         SRA: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
         SRL: next_value = {ser_in, value[WIDTH-1:1]};
         SLL: begin
            next_value = {value[WIDTH-2:0], ser_in};
            out_bit    = value[WIDTH-1];
         end
         ROR: next_value = {value[0], value[WIDTH-1:1]};
         default: next_value = value;
      endcase
   end
endmodule

// File: rtl/shift_reg_ctl.sv
// Shift register with parallel load, single-step shift and multi-step shift FSM.
// Multi-step: Start accepted at edge k shifts at edges k+1..k+n, Done pulses after edge k+n.
module shift_reg_ctl
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             Carga,
   input  logic             Desplaza,
   input  logic             Start,
   input  logic [1:0]       Modo,
   input  logic [CW-1:0]    Cant,
   input  logic             SerIn,
   input  logic [WIDTH-1:0] entA,
   output logic [WIDTH-1:0] q,
   output logic             SerOut,
   output logic             Busy,
   output logic             Done
);
   localparam int CNTW = $clog2(WIDTH + 1);

   state_e           state;
   mode_e            mode_r;
   logic [CNTW-1:0]  cnt;
   logic [CNTW-1:0]  cnt_ld;
   mode_e            step_mode;
   logic [WIDTH-1:0] step_q;
   logic             step_out;

   // While shifting, the captured mode drives the stepper so Modo changes are ignored.
   assign step_mode = (state == SHIFT) ? mode_r : mode_e'(Modo);

   always_comb begin
      cnt_ld = CNTW'(Cant);
      if (32'(Cant) > 32'(WIDTH)) cnt_ld = CNTW'(WIDTH);
   end

   shift_step #(.WIDTH(WIDTH)) u_step (
      .value      (q),
      .mode       (step_mode),
      .ser_in     (SerIn),
      .next_value (step_q),
      .out_bit    (step_out)
   );

   // Busy/Done are flops written alongside state so they never glitch.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         mode_r <= SRA;
         cnt    <= '0;
         q      <= '0;
         SerOut <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         Busy <= 1'b0;
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Carga) begin
                  q <= entA;
               end else if (Start) begin
                  if (cnt_ld == '0) begin
                     state <= DONE;
                     Done  <= 1'b1;
                  end else begin
                     mode_r <= mode_e'(Modo);
                     cnt    <= cnt_ld;
                     state  <= SHIFT;
                     Busy   <= 1'b1;
                  end
               end else if (Desplaza) begin
                  q      <= step_q;
                  SerOut <= step_out;
               end
            end
            SHIFT: begin
               q      <= step_q;
               SerOut <= step_out;
               cnt    <= cnt - CNTW'(1);
               if (cnt == CNTW'(1)) begin
                  state <= DONE;
                  Done  <= 1'b1;
               end else begin
                  Busy <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shift_reg_ctl.sv
// Bench for shift_reg_ctl: vector table for IDLE operations, scoreboard for multi-step shifts.
module tb_shift_reg_ctl;
   import shift_pkg::*;

   logic       clk;
   logic       Reset;
   logic       Carga, Desplaza, Start, SerIn;
   logic [1:0] Modo;
   logic [3:0] Cant;
   logic [7:0] entA;
   logic [7:0] q;
   logic       SerOut, Busy, Done;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] mq;
   logic       mso;
   logic [8:0] sb_q[$];

   typedef struct {
      logic       carga;
      logic       desp;
      logic [1:0] modo;
      logic       sin;
      logic [7:0] enta;
      logic [7:0] exp_q;
      logic       exp_so;
   } vec_t;
   vec_t tbl[12];

   shift_reg_ctl #(.WIDTH(8)) dut (
      .clk      (clk),
      .Reset    (Reset),
      .Carga    (Carga),
      .Desplaza (Desplaza),
      .Start    (Start),
      .Modo     (Modo),
      .Cant     (Cant),
      .SerIn    (SerIn),
      .entA     (entA),
      .q        (q),
      .SerOut   (SerOut),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns {out_bit, next_value} for one shift of v.
   function automatic logic [8:0] mstep(input logic [7:0] v, input logic [1:0] m, input logic s);
      logic [8:0] r;
      case (m)
         2'b00:   r = {v[0], v[7], v[7:1]};
         2'b01:   r = {v[0], s, v[7:1]};
         2'b10:   r = {v[7], v[6:0], s};
         default: r = {v[0], v[0], v[7:1]};
      endcase
      return r;
   endfunction

   task automatic load(input logic [7:0] v);
      Carga = 1'b1;
      entA  = v;
      step();
      Carga = 1'b0;
      mq    = v;
      chk("load q", q, v);
   endtask

   task automatic run_start(input logic [1:0] m, input logic [3:0] c, input logic s,
                            input bit junk, input string tag);
      int         n;
      int         busy_cnt;
      logic [7:0] q0;
      logic [8:0] r;
      logic [8:0] e;
      n  = (c > 4'd8) ? 8 : int'(c);
      q0 = mq;
      for (int i = 0; i < n; i++) begin
         r   = mstep(mq, m, s);
         mq  = r[7:0];
         mso = r[8];
         sb_q.push_back(r);
      end
      Start = 1'b1;
      Modo  = m;
      Cant  = c;
      SerIn = s;
      step();
      busy_cnt = 0;
      chk({tag, " accept q"}, q, q0);
      chk({tag, " accept busy"}, Busy, n > 0);
      chk({tag, " accept done"}, Done, n == 0);
      if (Busy) busy_cnt++;
      if (junk) begin
         Carga    = 1'b1;
         Desplaza = 1'b1;
         entA     = 8'hFF;
         Modo     = ~m;
         Cant     = 4'd1;
      end else begin
         Start = 1'b0;
      end
      for (int j = 1; j <= n; j++) begin
         step();
         if (sb_q.size() == 0) begin
            chk({tag, " scoreboard underflow"}, 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk({tag, " shift q"}, q, e[7:0]);
            chk({tag, " shift serout"}, SerOut, e[8]);
         end
         chk({tag, " shift busy"}, Busy, j < n);
         chk({tag, " shift done"}, Done, j == n);
         if (Busy) busy_cnt++;
      end
      Carga    = 1'b0;
      Desplaza = 1'b0;
      Start    = 1'b0;
      step();
      chk({tag, " after done"}, Done, 0);
      chk({tag, " after busy"}, Busy, 0);
      chk({tag, " busy cycles"}, busy_cnt, n);
      chk({tag, " final q"}, q, mq);
   endtask

   initial begin
      bit done_seen;
      tbl[0]  = '{1'b1, 1'b0, SRA, 1'b0, 8'hB4, 8'hB4, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, SRA, 1'b0, 8'h00, 8'hDA, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, SRL, 1'b1, 8'h00, 8'hED, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, SLL, 1'b0, 8'h00, 8'hDA, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, ROR, 1'b0, 8'h00, 8'h6D, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, SRA, 1'b0, 8'h81, 8'h81, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, SLL, 1'b1, 8'h00, 8'h03, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, SRA, 1'b0, 8'h5A, 8'h5A, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, ROR, 1'b0, 8'h00, 8'h2D, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, SLL, 1'b1, 8'hFF, 8'h2D, 1'b0};
      tbl[10] = '{1'b0, 1'b1, SRL, 1'b1, 8'h00, 8'h96, 1'b1};
      tbl[11] = '{1'b0, 1'b1, SRA, 1'b0, 8'h00, 8'hCB, 1'b0};

      Reset = 1'b1; Carga = 1'b0; Desplaza = 1'b0; Start = 1'b0;
      Modo = 2'b00; Cant = 4'd0; SerIn = 1'b0; entA = 8'h00;
      mq = 8'h00; mso = 1'b0;
      #3;
      chk("reset q", q, 8'h00);
      chk("reset serout", SerOut, 0);
      chk("reset busy", Busy, 0);
      chk("reset done", Done, 0);
      step();
      Reset = 1'b0;

      foreach (tbl[i]) begin
         Carga    = tbl[i].carga;
         Desplaza = tbl[i].desp;
         Modo     = tbl[i].modo;
         SerIn    = tbl[i].sin;
         entA     = tbl[i].enta;
         step();
         chk($sformatf("vec%0d q", i), q, tbl[i].exp_q);
         chk($sformatf("vec%0d serout", i), SerOut, tbl[i].exp_so);
         chk($sformatf("vec%0d busy", i), Busy, 0);
         chk($sformatf("vec%0d done", i), Done, 0);
         mq  = tbl[i].exp_q;
         mso = tbl[i].exp_so;
      end
      Carga = 1'b0; Desplaza = 1'b0;

      load(8'hB4);
      run_start(SRA, 4'd3, 1'b0, 1'b0, "sra3");
      chk("sra3 const q", q, 8'hF6);
      chk("sra3 const serout", SerOut, 1);

      load(8'hB4);
      run_start(SRL, 4'd3, 1'b0, 1'b0, "srl3");
      chk("srl3 const q", q, 8'h16);
      chk("srl3 const serout", SerOut, 1);

      load(8'h01);
      run_start(ROR, 4'd8, 1'b0, 1'b0, "ror8");
      chk("ror8 const q", q, 8'h01);
      run_start(ROR, 4'd15, 1'b0, 1'b0, "ror15");
      chk("ror15 const q", q, 8'h01);

      load(8'hA5);
      run_start(SRA, 4'd0, 1'b0, 1'b0, "cant0");
      chk("cant0 const q", q, 8'hA5);

      Carga = 1'b1; Start = 1'b1; Desplaza = 1'b1; entA = 8'h3C; Cant = 4'd2; Modo = SRA;
      step();
      chk("all-req q", q, 8'h3C);
      chk("all-req busy", Busy, 0);
      chk("all-req done", Done, 0);
      Carga = 1'b0; Start = 1'b0; Desplaza = 1'b0;
      step();
      chk("all-req done next", Done, 0);
      chk("all-req q next", q, 8'h3C);
      mq = 8'h3C;

      load(8'h0F);
      run_start(SRL, 4'd4, 1'b1, 1'b1, "ignore");
      chk("ignore const q", q, 8'hF0);
      chk("ignore const serout", SerOut, 1);

      load(8'hC3);
      Start = 1'b1; Modo = SRA; Cant = 4'd5;
      step();
      Start = 1'b0;
      chk("rst-mid busy", Busy, 1);
      step();
      step();
      chk("rst-mid q before", q, 8'hF0);
      #2;
      Reset = 1'b1;
      #1;
      chk("rst-mid q", q, 8'h00);
      chk("rst-mid busy0", Busy, 0);
      chk("rst-mid done0", Done, 0);
      chk("rst-mid serout", SerOut, 0);
      done_seen = 1'b0;
      step();
      done_seen |= Done;
      step();
      done_seen |= Done;
      Reset = 1'b0;
      mq = 8'h00; mso = 1'b0;
      load(8'h3C);
      for (int i = 0; i < 8; i++) begin
         step();
         done_seen |= Done;
         if (Busy) done_seen = 1'b1;
      end
      chk("rst-mid no done", done_seen, 0);
      chk("rst-mid q after", q, 8'h3C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/shift_reg_ctl.md
SHIFT_REG_CTL -- requirements
Module: shift_reg_ctl

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>= 2).
REQ-002 Parameter CW, default $clog2(WIDTH)+1, width of the shift-amount port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  reset, asynchronous, active-high.
REQ-005 Carga  input  1  parallel-load request.
REQ-006 Desplaza  input  1  single-step shift request (one position, mode Modo).
REQ-007 Start  input  1  multi-step shift request (Cant positions, mode Modo).
REQ-008 Modo  input  2  00 SRA (MSB replicated), 01 SRL (SerIn into MSB), 10 SLL (SerIn into LSB), 11 ROR (LSB into MSB).
REQ-009 Cant  input  CW  shift amount for Start.
REQ-010 SerIn  input  1  serial input bit for SRL/SLL.
REQ-011 entA  input  WIDTH  parallel load data.
REQ-012 q  output  WIDTH  register contents.
REQ-013 SerOut  output  1  registered copy of the bit shifted out by the most recent shift step.
REQ-014 Busy  output  1  high while in SHIFT state.
REQ-015 Done  output  1  one-cycle pulse marking completion of a Start operation.

Function
REQ-016 FSM states: IDLE, SHIFT, DONE. Carga, Desplaza and Start are sampled only in IDLE; they are ignored in SHIFT and DONE.
REQ-017 In IDLE, priority is Carga > Start > Desplaza; only the highest-priority asserted request acts in a cycle.
REQ-018 Carga in IDLE: q <= entA on the edge; SerOut unchanged; state stays IDLE.
REQ-019 Desplaza in IDLE: q shifted one position per Modo on the edge; SerOut <= bit shifted out (bit 0 for SRA/SRL/ROR, bit WIDTH-1 for SLL); state stays IDLE.
REQ-020 Start in IDLE with Cant = 0: q unchanged; next state DONE.
REQ-021 Start in IDLE with Cant > 0: Modo and min(Cant, WIDTH) captured into internal registers; q not shifted on that edge; next state SHIFT.
REQ-022 In SHIFT: each edge applies one shift step using the captured mode and decrements the remaining count; on the edge that applies the last step, next state is DONE.
REQ-023 Modo and Cant changes during SHIFT have no effect on the operation in progress.
REQ-024 Busy = 1 exactly in SHIFT (Cant cycles); Done = 1 exactly in DONE (one cycle); DONE always returns to IDLE on the next edge.
REQ-025 Timing: Start accepted at edge k with Cant = n > 0 -> shifts at edges k+1 .. k+n, Done high from edge k+n to edge k+n+1.
REQ-026 Busy and Done are decoded from state registers, glitch-free, never both high.

Reset
REQ-027 Reset asserted: immediately, independent of clk, q = 0, SerOut = 0, Busy = 0, Done = 0, state = IDLE, count and captured mode = 0.
REQ-028 Reset asserted mid-SHIFT or in DONE aborts the operation; no Done pulse is produced for it.
REQ-029 After Reset deasserts, the first rising edge can accept a request.

Structure
REQ-030 Package shift_pkg holds the Modo encodings (SRA, SRL, SLL, ROR) and the state enumeration.
REQ-031 One sub-module, shift_step: combinational one-position shifter (inputs value, mode, SerIn; outputs next value and out bit), shared by Desplaza and SHIFT paths.

Verification (WIDTH = 8)
REQ-032 Carga entA=8'hB4; Start Modo=SRA Cant=3 -> Busy 3 cycles, q=8'hDA, 8'hED, 8'hF6; Done one cycle; SerOut=1.
REQ-033 Carga 8'hB4; Start Modo=SRL Cant=3 SerIn=0 -> q=8'h16, SerOut=1; Carga 8'h81, Desplaza Modo=SLL SerIn=1 -> q=8'h03, SerOut=1.
REQ-034 Carga 8'h01; Start Modo=ROR Cant=8 -> q=8'h01 after 8 Busy cycles; repeat with Cant=15 -> clamped to 8, same result, Busy 8 cycles.
REQ-035 Start Cant=0 -> no Busy, Done next cycle, q unchanged; Carga+Start+Desplaza same IDLE cycle -> q=entA only, no Done.
REQ-036 Start Cant=5, Reset asserted during 3rd SHIFT cycle -> q=8'h00, Busy=0, Done never pulses; Carga/Start/Desplaza asserted during SHIFT -> ignored.
